// File: rtl/stim_pkg.sv
// Shared types and helpers for the stimulus/toggle-count block: FSM state
// encoding, LFSR feedback mask and step, 4-bit popcount, and the golden
// reference function of the 4-input sub-circuit.
package stim_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        SAMPLE = 2'd2,
        DONE   = 2'd3
    } stim_state_t;

    localparam logic [7:0] LFSR_MASK = 8'hB8;

    // One step of the 8-bit right-shifting Galois LFSR.
    function automatic logic [7:0] lfsr_next(input logic [7:0] l);
        return (l >> 1) ^ (l[0] ? LFSR_MASK : 8'h00);
    endfunction

    function automatic logic [2:0] popcount4(input logic [3:0] v);
        return {2'b00, v[0]} + {2'b00, v[1]} + {2'b00, v[2]} + {2'b00, v[3]};
    endfunction

    // Reference output of the sub-circuit; bit0 of v is input 1.
    function automatic logic golden(input logic [3:0] v);
        return (v[0] & v[3]) | (~(v[0] ^ v[1]) & (v[1] ^ v[2]));
    endfunction

endpackage

// File: rtl/stim_lfsr8.sv
// 8-bit Galois LFSR with reload and step controls. The reload path steps
// the seed in the same edge, so the value after a reload is already the
// successor of SEED.
module stim_lfsr8
    import stim_pkg::*;
#(
    parameter logic [7:0] SEED = 8'h01
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic       en,
    output logic [3:0] vec
);

    logic [7:0] value;

    // LFSR state: reset to SEED, reload-and-step, or plain step.
    always_ff @(posedge clk) begin
        if (rst) begin
            value <= SEED;
        end else if (load) begin
            value <= lfsr_next(SEED);
        end else if (en) begin
            value <= lfsr_next(value);
        end
    end

    assign vec = value[3:0];

endmodule

// File: rtl/stim_toggle_driver.sv
// Stimulus driver for the 4-input sub-circuit experiments: applies LFSR
// vectors, samples the sub-circuit output after SETTLE_CYC cycles and
// accumulates input/output toggle counts for activity estimation.
// Optional build macro: STIM_GOLDEN_CHECK_EN adds a golden-model check and
// the mismatch_cnt output.
module stim_toggle_driver
    import stim_pkg::*;
#(
    parameter int         VEC_CNT_W  = 16,
    parameter logic [7:0] SEED       = 8'h01,
    parameter int         SETTLE_CYC = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [VEC_CNT_W-1:0] num_vec,
    output logic                 busy,
    output logic                 done,
    output logic [3:0]           dut_in,
    input  logic                 dut_out,
    output logic [VEC_CNT_W+1:0] in_toggles,
    output logic [VEC_CNT_W-1:0] out_toggles
`ifdef STIM_GOLDEN_CHECK_EN
    ,
    output logic [VEC_CNT_W-1:0] mismatch_cnt
`endif
);

    localparam int IW = VEC_CNT_W + 2;
    localparam int SW = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
    localparam logic [VEC_CNT_W-1:0] VEC_ONE    = VEC_CNT_W'(1);
    localparam logic [SW-1:0]        SETTLE_END = SW'(SETTLE_CYC - 1);

    if (SEED == 8'h00) begin : g_bad_seed
        $error("stim_toggle_driver: SEED must be nonzero");
    end
    if (SETTLE_CYC < 1) begin : g_bad_settle
        $error("stim_toggle_driver: SETTLE_CYC must be at least 1");
    end

    stim_state_t          state, state_next;
    logic                 accept;
    logic                 last_vec;
    logic                 settle_last;
    logic                 load_next;
    logic [VEC_CNT_W-1:0] num_vec_q;
    logic [VEC_CNT_W-1:0] vec_cnt;
    logic [SW-1:0]        settle_cnt;
    logic                 prev_valid;
    logic                 prev_sample;
    logic [3:0]           lfsr_vec;
    logic [3:0]           load_vec;
    logic [IW-1:0]        in_base;
    logic [IW:0]          in_raw;
    logic [IW-1:0]        in_sum;

    stim_lfsr8 #(.SEED(SEED)) u_lfsr (
        .clk  (clk),
        .rst  (rst),
        .load (accept),
        .en   (load_next),
        .vec  (lfsr_vec)
    );

    assign settle_last = (settle_cnt == SETTLE_END);
    assign last_vec    = (vec_cnt == (num_vec_q - VEC_ONE));

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode and handshake/strobe outputs.
    always_comb begin
        state_next = state;
        accept     = 1'b0;
        load_next  = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) begin
                    accept     = 1'b1;
                    state_next = (num_vec == '0) ? DONE : SETTLE;
                end
            end
            SETTLE: begin
                busy = 1'b1;
                if (settle_last) begin
                    state_next = SAMPLE;
                end
            end
            SAMPLE: begin
                busy = 1'b1;
                if (last_vec) begin
                    state_next = DONE;
                end else begin
                    load_next  = 1'b1;
                    state_next = SETTLE;
                end
            end
            DONE: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Next vector and saturating input-toggle sum; a fresh run starts the
    // sum from zero but still measures flips against the held dut_in.
    always_comb begin
        load_vec = accept ? SEED[3:0] : lfsr_vec;
        in_base  = accept ? '0 : in_toggles;
        in_raw   = {1'b0, in_base} + (IW + 1)'(popcount4(load_vec ^ dut_in));
        in_sum   = in_raw[IW] ? '1 : in_raw[IW-1:0];
    end

    // Datapath: vector register, settle timer, sampling and counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            dut_in       <= '0;
            in_toggles   <= '0;
            out_toggles  <= '0;
            num_vec_q    <= '0;
            vec_cnt      <= '0;
            settle_cnt   <= '0;
            prev_valid   <= 1'b0;
            prev_sample  <= 1'b0;
`ifdef STIM_GOLDEN_CHECK_EN
            mismatch_cnt <= '0;
`endif
        end else begin
            if (accept) begin
                num_vec_q    <= num_vec;
                vec_cnt      <= '0;
                settle_cnt   <= '0;
                prev_valid   <= 1'b0;
                out_toggles  <= '0;
                in_toggles   <= '0;
`ifdef STIM_GOLDEN_CHECK_EN
                mismatch_cnt <= '0;
`endif
                if (num_vec != '0) begin
                    dut_in     <= load_vec;
                    in_toggles <= in_sum;
                end
            end

            if (state == SETTLE) begin
                settle_cnt <= settle_last ? '0 : settle_cnt + SW'(1);
            end

            if (state == SAMPLE) begin
                prev_sample <= dut_out;
                prev_valid  <= 1'b1;
                vec_cnt     <= vec_cnt + VEC_ONE;
                if (prev_valid && (dut_out != prev_sample) && (out_toggles != '1)) begin
                    out_toggles <= out_toggles + VEC_ONE;
                end
`ifdef STIM_GOLDEN_CHECK_EN
                if ((dut_out != golden(dut_in)) && (mismatch_cnt != '1)) begin
                    mismatch_cnt <= mismatch_cnt + VEC_ONE;
                end
`endif
                if (load_next) begin
                    dut_in     <= load_vec;
                    in_toggles <= in_sum;
                end
            end
        end
    end

endmodule
